mult_seq_core: RTL and testbench



---
 rtl/mult_seq_core_pkg.sv | 33 +++
 rtl/mult_pp_step.sv | 24 ++
 rtl/mult_seq_core.sv | 111 +++++++++++
 tb/tb_mult_seq_core.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mult_seq_core_pkg.sv
// Shared definitions for the EX-stage multiply path: widths, multiplier
// sequencer states and the ALU operation encodings.
package mult_seq_core_pkg;

  localparam int MULT_WIDTH    = 32;
  localparam int PRODUCT_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10
  } alu_op_e;

  // Number of BUSY iterations needed to retire every multiplier bit.
  function automatic int mult_steps(input int step_bits);
    return MULT_WIDTH / step_bits;
  endfunction

endpackage

// File: rtl/mult_pp_step.sv
// One radix-2^STEP_BITS iteration: partial product of the multiplicand and
// one multiplier digit, aligned by shift_i and added into the accumulator.
module mult_pp_step
  import mult_seq_core_pkg::*;
#(
  parameter int STEP_BITS = 2
) (
  input  logic [PRODUCT_WIDTH-1:0] acc_i,
  input  logic [MULT_WIDTH-1:0]    mcand_i,
  input  logic [STEP_BITS-1:0]     digit_i,
  input  logic [5:0]               shift_i,
  output logic [PRODUCT_WIDTH-1:0] acc_o
);

  localparam int PP_W = MULT_WIDTH + STEP_BITS;

  logic [PP_W-1:0]          pp;
  logic [PRODUCT_WIDTH-1:0] pp_ext;

  assign pp     = {{STEP_BITS{1'b0}}, mcand_i} * {{MULT_WIDTH{1'b0}}, digit_i};
  assign pp_ext = {{(PRODUCT_WIDTH-PP_W){1'b0}}, pp};
  assign acc_o  = acc_i + (pp_ext << shift_i);

endmodule

// File: rtl/mult_seq_core.sv
// Iterative unsigned 32x32->64 multiplier answering the start/ready handshake
// of the EX-stage multiply front end; STEP_BITS multiplier bits per BUSY cycle.
module mult_seq_core
  import mult_seq_core_pkg::*;
#(
  parameter int STEP_BITS  = 2,
  parameter int EARLY_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MULT_WIDTH-1:0]    mcand,
  input  logic [MULT_WIDTH-1:0]    mplier,
  input  logic                     start_i,
  input  logic                     flush,
  output logic [PRODUCT_WIDTH-1:0] result_o,
  output logic                     ready_o
);

  localparam int              NSTEPS = mult_steps(STEP_BITS);
  localparam int              CNT_W  = 6;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NSTEPS - 1);

  mult_state_e              state_q,  state_d;
  logic [MULT_WIDTH-1:0]    mcand_q,  mcand_d;
  logic [MULT_WIDTH-1:0]    mplier_q, mplier_d;
  logic [PRODUCT_WIDTH-1:0] acc_q,    acc_d;
  logic [PRODUCT_WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0]         cnt_q,    cnt_d;
  logic                     ready_q,  ready_d;

  logic [PRODUCT_WIDTH-1:0] acc_step;
  logic [CNT_W-1:0]         shift;
  logic                     zero_op;

  assign shift   = cnt_q * CNT_W'(STEP_BITS);
  assign zero_op = (mcand == '0) || (mplier == '0);

  mult_pp_step #(.STEP_BITS(STEP_BITS)) u_pp_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .digit_i (mplier_q[STEP_BITS-1:0]),
    .shift_i (shift),
    .acc_o   (acc_step)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    // Flush discards everything in flight but leaves the last product visible.
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mcand_d  = mcand;
            mplier_d = mplier;
            acc_d    = '0;
            cnt_d    = '0;
            if ((EARLY_ZERO != 0) && zero_op) begin
              result_d = '0;
              state_d  = ST_DONE;
            end else begin
              state_d  = ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          acc_d    = acc_step;
          mplier_d = mplier_q >> STEP_BITS;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            result_d = acc_step;
            state_d  = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    ready_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_mult_seq_core.sv
// Self-checking bench for mult_seq_core: four instances covering STEP_BITS
// 1/2/4 and EARLY_ZERO on/off, checked against plain 64-bit arithmetic.
module tb_mult_seq_core;

  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst    [ND];
  logic [31:0] mcand  [ND];
  logic [31:0] mplier [ND];
  logic        start  [ND];
  logic        flush  [ND];
  logic [63:0] result [ND];
  logic        ready  [ND];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_seq_core #(.STEP_BITS(2), .EARLY_ZERO(1)) u_s2 (
    .clk(clk), .rst(rst[0]), .mcand(mcand[0]), .mplier(mplier[0]), .start_i(start[0]),
    .flush(flush[0]), .result_o(result[0]), .ready_o(ready[0]));
  mult_seq_core #(.STEP_BITS(1), .EARLY_ZERO(1)) u_s1 (
    .clk(clk), .rst(rst[1]), .mcand(mcand[1]), .mplier(mplier[1]), .start_i(start[1]),
    .flush(flush[1]), .result_o(result[1]), .ready_o(ready[1]));
  mult_seq_core #(.STEP_BITS(4), .EARLY_ZERO(1)) u_s4 (
    .clk(clk), .rst(rst[2]), .mcand(mcand[2]), .mplier(mplier[2]), .start_i(start[2]),
    .flush(flush[2]), .result_o(result[2]), .ready_o(ready[2]));
  mult_seq_core #(.STEP_BITS(2), .EARLY_ZERO(0)) u_nz (
    .clk(clk), .rst(rst[3]), .mcand(mcand[3]), .mplier(mplier[3]), .start_i(start[3]),
    .flush(flush[3]), .result_o(result[3]), .ready_o(ready[3]));

  function automatic int step_of(input int d);
    case (d)
      1:       return 1;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  // Cycles from the accepting edge until ready_o is seen (cycle 1 = first after it).
  function automatic int lat_of(input int d, input logic [31:0] a, input logic [31:0] b);
    if ((d != 3) && ((a == 0) || (b == 0))) return 1;
    return 32 / step_of(d) + 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input int d, input logic [31:0] a, input logic [31:0] b,
                    input bit toggle, input string tag);
    logic [63:0] exp;
    int          cyc;
    bit          seen;
    exp      = {32'd0, a} * {32'd0, b};
    mcand[d]  = a;
    mplier[d] = b;
    start[d]  = 1'b1;
    @(posedge clk); #1;
    cyc  = 1;
    seen = 1'b0;
    while (cyc < 100) begin
      if (ready[d]) begin
        seen = 1'b1;
        break;
      end
      if (toggle) begin
        mcand[d]  = $urandom;
        mplier[d] = $urandom;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start[d] = 1'b0;
    chk({tag, " latency"}, seen ? 64'(cyc) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(lat_of(d, a, b)));
    chk({tag, " result"}, result[d], exp);
    @(posedge clk); #1;
    chk({tag, " pulse"}, {63'd0, ready[d]}, 64'd0);
    chk({tag, " hold"}, result[d], exp);
  endtask

  // Counts ready_o pulses over a window with no request pending.
  task automatic quiet(input int d, input int ncyc, input string tag);
    int hits;
    hits = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (ready[d]) hits++;
    end
    chk({tag, " no ready"}, 64'(hits), 64'd0);
  endtask

  initial begin
    logic [63:0] prior;
    logic [31:0] ra, rb;
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b1; mcand[d] = '0; mplier[d] = '0; start[d] = 1'b0; flush[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset ready d%0d", d), {63'd0, ready[d]}, 64'd0);
      chk($sformatf("reset result d%0d", d), result[d], 64'd0);
      rst[d] = 1'b0;
    end

    op(0, 32'd3, 32'd5, 1'b0, "3x5");
    op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max s2");
    op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max s1");
    op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max s4");
    op(0, 32'h1234_5678, 32'd0, 1'b0, "zero ez");
    op(3, 32'h1234_5678, 32'd0, 1'b0, "zero noez");
    op(0, 32'd0, 32'h8765_4321, 1'b0, "zero mcand ez");

    // Flush in the 8th BUSY cycle.
    op(0, 32'd9, 32'd11, 1'b0, "pre flush");
    prior = result[0];
    mcand[0] = 32'hDEAD_BEEF; mplier[0] = 32'd2; start[0] = 1'b1;
    @(posedge clk); #1;
    repeat (7) @(posedge clk);
    #1;
    flush[0] = 1'b1; start[0] = 1'b0;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    chk("flush ready", {63'd0, ready[0]}, 64'd0);
    chk("flush result", result[0], prior);
    quiet(0, 20, "flush");
    chk("flush result later", result[0], prior);
    op(0, 32'd7, 32'd6, 1'b0, "7x6");

    // Start coinciding with flush in IDLE is not accepted.
    mcand[0] = 32'd100; mplier[0] = 32'd100; start[0] = 1'b1; flush[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0; flush[0] = 1'b0;
    quiet(0, 20, "flush+start");

    // Back-to-back, second request with busy-time operand noise.
    op(0, 32'h0001_0000, 32'h0001_0000, 1'b0, "b2b first");
    op(0, 32'h8000_0000, 32'd2, 1'b1, "b2b second");

    // Reset in the 5th BUSY cycle.
    mcand[0] = 32'h0F0F_0F0F; mplier[0] = 32'h3333_3333; start[0] = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    rst[0] = 1'b1; start[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    chk("rst ready", {63'd0, ready[0]}, 64'd0);
    chk("rst result", result[0], 64'd0);
    quiet(0, 20, "rst");
    op(0, 32'hCAFE_F00D, 32'h0000_1234, 1'b0, "after rst");

    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < 4; k++) begin
        ra = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
        rb = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
        op(d, ra, rb, 1'b1, $sformatf("rand d%0d k%0d", d, k));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
